rx_event_sync: RTL

Parametrised clock-domain bridge for receiver status, placed between the netclk-domain deframer and clock-detect logic and the system-clock host interface. It synchronises N_EVT event lines and N_LVL level lines into clk with a configurable synchroniser depth. It converts rising edges on event lines into single-cycle pulses and holds sticky pending and overrun flags with write-1-to-clear. It drives a masked, registered interrupt and can optionally count events per channel.

---
 rtl/rx_event_sync_if.sv | 30 +++
 rtl/rx_event_sync.sv | 112 +++++++++++
 2 files changed

// File: rtl/rx_event_sync_if.sv
// Signal bundle between the receiver status bridge and its host-side register block.
// Host side drives the inputs through master; rx_event_sync uses slave.
interface rx_event_sync_if #(
    parameter int N_EVT = 2,
    parameter int N_LVL = 3,
    parameter int CNT_W = 8
);
    logic [N_EVT-1:0] evt_in;
    logic [N_LVL-1:0] lvl_in;
    logic [N_EVT-1:0] evt_clr;
    logic [N_EVT-1:0] irq_mask;
    logic [3:0]       cnt_sel;
    logic             cnt_clr;
    logic [N_EVT-1:0] evt_pulse;
    logic [N_LVL-1:0] lvl_out;
    logic [N_EVT-1:0] evt_pending;
    logic [N_EVT-1:0] evt_overrun;
    logic             irq;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output evt_in, lvl_in, evt_clr, irq_mask, cnt_sel, cnt_clr,
        input  evt_pulse, lvl_out, evt_pending, evt_overrun, irq, cnt_out
    );

    modport slave (
        input  evt_in, lvl_in, evt_clr, irq_mask, cnt_sel, cnt_clr,
        output evt_pulse, lvl_out, evt_pending, evt_overrun, irq, cnt_out
    );
endinterface

// File: rtl/rx_event_sync.sv
// Netclk-to-clk bridge for receiver status: synchronised levels, edge pulses, sticky W1C flags, irq.
// Define RX_EVENT_COUNT_EN to build per-channel saturating event counters.
module rx_event_sync #(
    parameter int N_EVT       = 2,
    parameter int N_LVL       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    rx_event_sync_if.slave bus
);

    logic [SYNC_STAGES-1:0][N_EVT-1:0] r_evt_sync;
    logic [SYNC_STAGES-1:0][N_LVL-1:0] r_lvl_sync;
    logic [N_EVT-1:0]                  r_evt_hist;
    logic [N_EVT-1:0]                  r_evt_pulse;
    logic [N_EVT-1:0]                  r_pending;
    logic [N_EVT-1:0]                  r_overrun;
    logic                              r_irq;
    logic [N_EVT-1:0]                  w_evt_sync;
    logic [N_EVT-1:0]                  w_pending_nxt;
    logic [N_EVT-1:0]                  w_overrun_nxt;

    // Independent per-bit synchronisers; no cross-bit coherence is implied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_sync <= '0;
            r_lvl_sync <= '0;
        end else begin
            r_evt_sync <= {r_evt_sync[SYNC_STAGES-2:0], bus.evt_in};
            r_lvl_sync <= {r_lvl_sync[SYNC_STAGES-2:0], bus.lvl_in};
        end
    end

    assign w_evt_sync = r_evt_sync[SYNC_STAGES-1];

    // History resets low so a line already high at reset release yields one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_hist  <= '0;
            r_evt_pulse <= '0;
        end else begin
            r_evt_hist  <= w_evt_sync;
            r_evt_pulse <= w_evt_sync & ~r_evt_hist;
        end
    end

    // A pulse coincident with a clear wins for pending but never counts as overrun.
    always_comb begin
        w_pending_nxt = r_evt_pulse | (r_pending & ~bus.evt_clr);
        w_overrun_nxt = ~bus.evt_clr & (r_overrun | (r_evt_pulse & r_pending));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            r_irq     <= |(r_pending & ~bus.irq_mask);
        end
    end

    assign bus.evt_pulse   = r_evt_pulse;
    assign bus.lvl_out     = r_lvl_sync[SYNC_STAGES-1];
    assign bus.evt_pending = r_pending;
    assign bus.evt_overrun = r_overrun;
    assign bus.irq         = r_irq;

`ifdef RX_EVENT_COUNT_EN
    logic [CNT_W-1:0] r_cnt [N_EVT];
    logic [CNT_W-1:0] r_cnt_out;
    logic [CNT_W-1:0] w_cnt_sel;

    // Clear of the selected channel takes priority; a same-cycle pulse restarts it at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_EVT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_EVT; i++) begin
                if (bus.cnt_clr && (bus.cnt_sel == 4'(i))) begin
                    r_cnt[i] <= CNT_W'(r_evt_pulse[i]);
                end else if (r_evt_pulse[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Unpopulated selector values fall through to zero.
    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (bus.cnt_sel == 4'(i)) w_cnt_sel = r_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt_out <= '0;
        else       r_cnt_out <= w_cnt_sel;
    end

    assign bus.cnt_out = r_cnt_out;
`else
    wire w_unused_cnt = &{1'b0, bus.cnt_sel, bus.cnt_clr};
    assign bus.cnt_out = '0;
`endif

endmodule
